div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 51 +++++
 rtl/div_ctrl_if.sv | 35 +++
 rtl/div_step.sv | 27 ++
 rtl/div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_div_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the iterative divider and its pipeline hookup:
//   - stall-bus geometry (width and the EX bit the divider drives)
//   - divider state encoding
//   - default iteration count and result width
//   - start/stop control constants used on the stall request
//   - helpers for operand magnitude and the signed result fix-up
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  // Stall bus seen by the pipeline controller; the divider feeds the EX bit.
  localparam int STALL_W  = 6;
  localparam int STALL_EX = 2;

  localparam int DATA_W             = 32;
  localparam int RESULT_W           = 64;   // {hi = remainder, lo = quotient}
  localparam int DIV_CYCLES_DEFAULT = 32;   // one quotient bit per BUSY cycle

  // Control levels for the stall request line.
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DIVZERO = 2'd2,
    S_DONE    = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement operand when signed, raw value otherwise.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                               input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  // Applies quotient/remainder signs to the unsigned core result and packs
  // it as {hi = remainder, lo = quotient}.
  function automatic logic [RESULT_W-1:0] fix_sign(input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] rem,
                                                   input logic              neg_quo,
                                                   input logic              neg_rem);
    logic [DATA_W-1:0] q_fixed;
    logic [DATA_W-1:0] r_fixed;
    q_fixed = neg_quo ? -quo : quo;
    r_fixed = neg_rem ? -rem : rem;
    return {r_fixed, q_fixed};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Handshake between the EX stage (master) and the divider (slave).
//   start       EX -> div  request; held high while EX is stalled
//   signed_div  EX -> div  1 = DIV, 0 = DIVU
//   cancel      EX -> div  flush, aborts any operation in progress
//   dividend    EX -> div  operand rs
//   divisor     EX -> div  operand rt
//   stallreq    div -> EX  stall request, drives the EX stall-bus bit
//   ready       div -> EX  one-cycle pulse qualifying result
//   result      div -> EX  {hi = remainder, lo = quotient}
// -----------------------------------------------------------------------------
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                start;
  logic                signed_div;
  logic                cancel;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                stallreq;
  logic                ready;
  logic [RESULT_W-1:0] result;

  modport master (
    output start, signed_div, cancel, dividend, divisor,
    input  stallreq, ready, result
  );

  modport slave (
    input  start, signed_div, cancel, dividend, divisor,
    output stallreq, ready, result
  );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i     33-bit partial remainder (previous remainder shifted left with
//             the next dividend bit appended)
//   divisor_i 32-bit divisor magnitude
//   rem_o     next remainder (always < divisor, so 32 bits suffice)
//   qbit_o    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              qbit_o
);

  logic [DATA_W-1:0] diff;

  assign qbit_o = (rem_i >= {1'b0, divisor_i});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low 32 bits of a modulo-2^32 subtract are exact.
  assign diff   = rem_i[DATA_W-1:0] - divisor_i;
  assign rem_o  = qbit_o ? diff : rem_i[DATA_W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle restoring divider controller for the EX stage.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   div_ctrl_if.slave (start/signed_div/cancel/dividend/divisor in,
//         stallreq/ready/result out)
// Timeline for a nonzero divisor: acceptance in cycle 0, DIV_CYCLES BUSY
// cycles, DONE (ready) in cycle DIV_CYCLES+1. A zero divisor skips the
// iteration: DIVZERO in cycle 1, DONE in cycle 2.
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  localparam int             CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [DATA_W-1:0]   rem_q,    rem_d;     // running remainder
  logic [DATA_W-1:0]   quo_q,    quo_d;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   dvsr_q,   dvsr_d;
  logic                signed_q, signed_d;
  logic                sign_a_q, sign_a_d;  // dividend sign
  logic                sign_b_q, sign_b_d;  // divisor sign
  logic [RESULT_W-1:0] result_q, result_d;

  logic [DATA_W:0]     step_in;
  logic [DATA_W-1:0]   step_rem;
  logic                step_qbit;
  logic [DATA_W-1:0]   step_quo;
  logic                stallreq;
  logic                ready;

  assign step_in  = {rem_q, quo_q[DATA_W-1]};
  assign step_quo = {quo_q[DATA_W-2:0], step_qbit};

  div_step u_step (
    .rem_i     (step_in),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    stallreq = DIV_STOP;
    ready    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          stallreq = DIV_START;
          signed_d = bus.signed_div;
          sign_a_d = bus.signed_div & bus.dividend[DATA_W-1];
          sign_b_d = bus.signed_div & bus.divisor[DATA_W-1];
          dvsr_d   = abs_op(bus.divisor, bus.signed_div);
          rem_d    = '0;
          cnt_d    = '0;
          if (bus.divisor == '0) begin
            // Raw dividend is kept: it becomes the remainder unchanged.
            quo_d   = bus.dividend;
            state_d = S_DIVZERO;
          end else begin
            quo_d   = abs_op(bus.dividend, bus.signed_div);
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        stallreq = DIV_START;
        rem_d    = step_rem;
        quo_d    = step_quo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = fix_sign(step_quo, step_rem,
                              signed_q & (sign_a_q ^ sign_b_q),
                              signed_q & sign_a_q);
        end
      end

      S_DIVZERO: begin
        stallreq = DIV_START;
        state_d  = S_DONE;
        result_d = {quo_q, {DATA_W{1'b1}}};
      end

      S_DONE: begin
        // start is deliberately not looked at: the instruction that is
        // finishing here must not launch itself again.
        ready   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush wins over everything, including a completion in this cycle.
    if (bus.cancel) begin
      state_d  = S_IDLE;
      ready    = 1'b0;
      result_d = result_q;
    end

    // Nothing is requested or reported while reset is applied.
    if (rst) begin
      stallreq = DIV_STOP;
      ready    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  assign bus.stallreq = stallreq;
  assign bus.ready    = ready;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed, table-driven bench for div_ctrl. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Cycle 0 is the
// cycle in which start is first presented.
// -----------------------------------------------------------------------------
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one divide, holding start through DONE and dropping it afterwards.
  // Operands are scrambled after acceptance to show they are not re-read.
  task automatic do_div(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output logic stall_ok);
    bus.start      = 1'b1;
    bus.signed_div = sdiv;
    bus.dividend   = a;
    bus.divisor    = b;
    lat      = -1;
    res      = '0;
    stall_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat = c;
        res = bus.result;
        if (bus.stallreq) stall_ok = 1'b0;
      end else if (!bus.stallreq) begin
        stall_ok = 1'b0;
      end
      next_cycle();
      if (c == 0) begin
        bus.dividend   = ~a;
        bus.divisor    = 32'h3;
        bus.signed_div = ~sdiv;
      end
      if (lat >= 0) break;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic        stall_ok;
    int          rdy_at;
    int          n_rdy;
    logic        early_rdy;
    logic        s_sample;
    logic [63:0] r_sample;

    //            sdiv  dividend      divisor       lo            hi            lat
    vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2]  = '{1'b0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 2};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    vecs[4]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'h00000001, 33};
    vecs[8]  = '{1'b0, 32'd5,        32'd10,       32'h00000000, 32'h00000005, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 2};
    vecs[10] = '{1'b0, 32'hDEADBEEF, 32'h10,       32'h0DEADBEE, 32'h0000000F, 33};
    vecs[11] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000001, 32'h00000000, 33};
    vecs[12] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'h00000000, 33};

    // ---------------- reset ----------------
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.cancel     = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    next_cycle();
    next_cycle();
    bus.start    = 1'b1;              // request during reset must not stall
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    check("stallreq_in_reset", {63'd0, bus.stallreq}, 64'd0);
    next_cycle();
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("reset_stallreq", {63'd0, bus.stallreq}, 64'd0);
    check("reset_ready",    {63'd0, bus.ready},    64'd0);
    check("reset_result",   bus.result,            64'd0);
    next_cycle();

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      do_div(vecs[i].sdiv, vecs[i].a, vecs[i].b, lat, res, stall_ok);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_lo", i), {32'd0, res[31:0]},  {32'd0, vecs[i].exp_lo});
      check($sformatf("v%0d_hi", i), {32'd0, res[63:32]}, {32'd0, vecs[i].exp_hi});
      check($sformatf("v%0d_stall_shape", i), {63'd0, stall_ok}, 64'd1);
    end

    // ---------------- no retrigger after DONE ----------------
    n_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready) n_rdy++;
      next_cycle();
    end
    check("no_second_ready", 64'(n_rdy), 64'd0);
    check("result_holds", bus.result, {32'h00000000, 32'hC0000000});

    // ---------------- cancel together with start in IDLE ----------------
    bus.start      = 1'b1;
    bus.cancel     = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd50;
    bus.divisor    = 32'd5;
    @(negedge clk);
    check("cancel_start_stallreq", {63'd0, bus.stallreq}, 64'd0);
    next_cycle();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    n_rdy = 0;
    s_sample = 1'b0;
    for (int c = 1; c < 41; c++) begin
      @(negedge clk);
      if (bus.ready) n_rdy++;
      if (bus.stallreq) s_sample = 1'b1;
      next_cycle();
    end
    check("cancel_start_not_accepted", {62'd0, s_sample, 1'b0} | 64'(n_rdy), 64'd0);

    // ---------------- cancel mid-operation, then restart ----------------
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    rdy_at    = -1;
    early_rdy = 1'b0;
    s_sample  = 1'b1;
    r_sample  = '1;
    res       = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (c < 12) early_rdy = 1'b1;
        else if (rdy_at < 0) begin
          rdy_at = c;
          res    = bus.result;
        end
      end
      if (c == 11) begin
        s_sample = bus.stallreq;
        r_sample = bus.result;
      end
      next_cycle();
      if (c + 1 == 10) begin
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
      end
      if (c + 1 == 11) bus.cancel = 1'b0;
      if (c + 1 == 12) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
      end
      if (rdy_at >= 0) break;
    end
    bus.start = 1'b0;
    check("cancel_no_ready",      {63'd0, early_rdy}, 64'd0);
    check("cancel_idle_stallreq", {63'd0, s_sample},  64'd0);
    check("cancel_result_kept",   r_sample, {32'h00000000, 32'hC0000000});
    check("restart_latency",      64'(rdy_at), 64'd45);
    check("restart_result",       res, {32'd1, 32'd333});

    // ---------------- reset mid-operation ----------------
    next_cycle();
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    n_rdy = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.ready) n_rdy++;
      if (c == 20) check("stallreq_during_reset", {63'd0, bus.stallreq}, 64'd0);
      if (c == 21) begin
        check("post_reset_stallreq", {63'd0, bus.stallreq}, 64'd0);
        check("post_reset_ready",    {63'd0, bus.ready},    64'd0);
        check("post_reset_result",   bus.result,            64'd0);
      end
      next_cycle();
      if (c + 1 == 20) rst = 1'b1;
      if (c + 1 == 21) begin
        rst       = 1'b0;
        bus.start = 1'b0;
      end
    end
    check("reset_abort_no_ready", 64'(n_rdy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
